core_mem_responder: RTL and testbench

Memory-side responder for a core cluster's instruction and data request ports. It accepts fetch and load/store requests and arbitrates between them, serving one at a time. Each request becomes a 128-bit line transaction on a req/ack + rvalid memory port; fetch and load data return as full 128-bit lines. It sits between the core cluster and the DRAM/MMIO fabric, and is the far end of the cluster's `insn_addr` / `data_addr` / `data_ctrl` / `data_we` / `data_wdata` interface.

---
 rtl/core_mem_responder_pkg.sv | 33 +++
 rtl/core_mem_responder_wlane_gen.sv | 40 ++++
 rtl/core_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_core_mem_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_responder_pkg.sv
// Shared types and constants for the core-cluster memory responder.
// The line width, size encodings, error codes and FSM states all live here.
package core_mem_responder_pkg;

  localparam int LINE_W     = 128;
  localparam int LINE_BYTES = LINE_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_ILL = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Byte-enable pattern of an access before it is shifted into place.
  function automatic logic [3:0] size_pattern(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'h1;
      SZ_H:    return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/core_mem_responder_wlane_gen.sv
// Store lane generator: places a right-aligned 32-bit store into a 128-bit
// line with its byte mask, and flags misaligned or illegal-size accesses.
module mem_wlane_gen
  import core_mem_responder_pkg::*;
(
  input  logic [3:0]            addr_lo,
  input  logic [1:0]            size,
  input  logic [31:0]           wdata32,
  output logic [LINE_W-1:0]     wdata_line,
  output logic [LINE_BYTES-1:0] wmask,
  output logic                  misaligned
);

  logic [31:0] lane_word;
  logic [3:0]  lane_mask;

  // Replicating the store across the lane puts the data under every byte
  // enable, so no byte shift is needed for sub-word stores.
  always_comb begin
    case (size)
      SZ_B:    lane_word = {4{wdata32[7:0]}};
      SZ_H:    lane_word = {2{wdata32[15:0]}};
      default: lane_word = wdata32;
    endcase
  end

  assign lane_mask  = size_pattern(size) << addr_lo[1:0];

  assign misaligned = (size == SZ_ILL)
                    | ((size == SZ_H) & addr_lo[0])
                    | ((size == SZ_W) & (addr_lo[1:0] != 2'b00));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_line[gi*32 +: 32] = (addr_lo[3:2] == 2'(gi)) ? lane_word : 32'h0;
      assign wmask[gi*4 +: 4]        = (addr_lo[3:2] == 2'(gi)) ? lane_mask : 4'h0;
    end
  endgenerate

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder: latches fetch and load/store requests, serves one
// at a time (data first) as 128-bit line transactions on a req/ack+rvalid port.
module core_mem_responder
  import core_mem_responder_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int ADDR_W  = 32
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic                  i_insn_req,
  input  logic [ADDR_W-1:0]     i_insn_addr,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_W-1:0]     i_data_addr,
  input  logic [31:0]           i_data_wdata,
  input  logic [2:0]            i_data_ctrl,
  output logic [LINE_W-1:0]     o_insn_data,
  output logic [LINE_W-1:0]     o_data_data,
  output logic                  o_busy,
  output logic                  o_insn_done,
  output logic                  o_data_done,
  output logic [1:0]            o_err,
  output logic                  o_overrun,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [LINE_W-1:0]     o_mem_wdata,
  output logic [LINE_BYTES-1:0] o_mem_wmask,
  input  logic                  i_mem_ack,
  input  logic                  i_mem_rvalid,
  input  logic [LINE_W-1:0]     i_mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                  state_reg;
  logic                    serve_insn_reg;
  logic [1:0]              err_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    overrun_reg;

  logic                    data_pend_reg;
  logic                    data_we_reg;
  logic [ADDR_W-1:0]       data_addr_reg;
  logic [31:0]             data_wdata_reg;
  logic [1:0]              data_size_reg;
  logic                    insn_pend_reg;
  logic [ADDR_W-5:0]       insn_line_reg;

  logic [LINE_W-1:0]       insn_data_reg;
  logic [LINE_W-1:0]       data_data_reg;
  logic                    mem_we_reg;
  logic [ADDR_W-1:0]       mem_addr_reg;
  logic [LINE_W-1:0]       mem_wdata_reg;
  logic [LINE_BYTES-1:0]   mem_wmask_reg;

  // A pending latch takes precedence; otherwise a fresh pulse is used directly.
  logic                    data_valid;
  logic                    insn_valid;
  logic                    sel_data_we;
  logic [ADDR_W-1:0]       sel_data_addr;
  logic [31:0]             sel_data_wdata;
  logic [1:0]              sel_data_size;
  logic [ADDR_W-5:0]       sel_insn_line;

  logic [LINE_W-1:0]       lane_wdata;
  logic [LINE_BYTES-1:0]   lane_wmask;
  logic                    lane_misaligned;
  logic                    ctrl_unused;

  assign data_valid     = data_pend_reg | i_data_req;
  assign insn_valid     = insn_pend_reg | i_insn_req;
  assign sel_data_we    = data_pend_reg ? data_we_reg    : i_data_we;
  assign sel_data_addr  = data_pend_reg ? data_addr_reg  : i_data_addr;
  assign sel_data_wdata = data_pend_reg ? data_wdata_reg : i_data_wdata;
  assign sel_data_size  = data_pend_reg ? data_size_reg  : i_data_ctrl[1:0];
  assign sel_insn_line  = insn_pend_reg ? insn_line_reg  : i_insn_addr[ADDR_W-1:4];

  assign ctrl_unused    = &{1'b0, i_data_ctrl[2], i_insn_addr[3:0]};

  mem_wlane_gen u_wlane (
    .addr_lo    (sel_data_addr[3:0]),
    .size       (sel_data_size),
    .wdata32    (sel_data_wdata),
    .wdata_line (lane_wdata),
    .wmask      (lane_wmask),
    .misaligned (lane_misaligned)
  );

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_reg      <= ST_IDLE;
      serve_insn_reg <= 1'b0;
      err_reg        <= ERR_OK;
      cnt_reg        <= '0;
      overrun_reg    <= 1'b0;
      data_pend_reg  <= 1'b0;
      data_we_reg    <= 1'b0;
      data_addr_reg  <= '0;
      data_wdata_reg <= '0;
      data_size_reg  <= '0;
      insn_pend_reg  <= 1'b0;
      insn_line_reg  <= '0;
      insn_data_reg  <= '0;
      data_data_reg  <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_wmask_reg  <= '0;
    end else begin
      overrun_reg <= (i_data_req & data_pend_reg) | (i_insn_req & insn_pend_reg);

      if (i_data_req && !data_pend_reg) begin
        data_pend_reg  <= 1'b1;
        data_we_reg    <= i_data_we;
        data_addr_reg  <= i_data_addr;
        data_wdata_reg <= i_data_wdata;
        data_size_reg  <= i_data_ctrl[1:0];
      end
      if (i_insn_req && !insn_pend_reg) begin
        insn_pend_reg <= 1'b1;
        insn_line_reg <= i_insn_addr[ADDR_W-1:4];
      end

      case (state_reg)
        ST_IDLE: begin
          if (data_valid) begin
            serve_insn_reg <= 1'b0;
            if (lane_misaligned) begin
              err_reg   <= ERR_ALIGN;
              state_reg <= ST_RESP;
            end else begin
              err_reg       <= ERR_OK;
              mem_we_reg    <= sel_data_we;
              mem_addr_reg  <= {sel_data_addr[ADDR_W-1:4], 4'b0000};
              mem_wdata_reg <= sel_data_we ? lane_wdata : '0;
              mem_wmask_reg <= sel_data_we ? lane_wmask : '0;
              state_reg     <= ST_ISSUE;
            end
          end else if (insn_valid) begin
            serve_insn_reg <= 1'b1;
            err_reg        <= ERR_OK;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= {sel_insn_line, 4'b0000};
            mem_wdata_reg  <= '0;
            mem_wmask_reg  <= '0;
            state_reg      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_mem_ack) begin
            if (mem_we_reg) begin
              state_reg <= ST_RESP;
            end else begin
              cnt_reg   <= '0;
              state_reg <= ST_WAIT_R;
            end
          end
        end
        ST_WAIT_R: begin
          if (i_mem_rvalid) begin
            if (serve_insn_reg) insn_data_reg <= i_mem_rdata;
            else                data_data_reg <= i_mem_rdata;
            state_reg <= ST_RESP;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            if (serve_insn_reg) insn_data_reg <= '0;
            else                data_data_reg <= '0;
            err_reg   <= ERR_TIMEOUT;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          // ST_RESP: a pulse for this port cannot relatch here since its
          // pending bit is still set, so the clear below is never contested.
          if (serve_insn_reg) insn_pend_reg <= 1'b0;
          else                data_pend_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (state_reg != ST_IDLE);
  assign o_mem_req   = (state_reg == ST_ISSUE);
  assign o_insn_done = (state_reg == ST_RESP) &  serve_insn_reg;
  assign o_data_done = (state_reg == ST_RESP) & ~serve_insn_reg;
  assign o_err       = (state_reg == ST_RESP) ? err_reg : ERR_OK;
  assign o_overrun   = overrun_reg;
  assign o_insn_data = insn_data_reg;
  assign o_data_data = data_data_reg;
  assign o_mem_we    = mem_we_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;
  assign o_mem_wmask = mem_wmask_reg;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: a vector table of single
// transactions plus hand-written arbitration, timeout, overrun and reset cases.
module tb_core_mem_responder;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic          i_insn_req = 1'b0;
  logic [31:0]   i_insn_addr = '0;
  logic          i_data_req = 1'b0;
  logic          i_data_we = 1'b0;
  logic [31:0]   i_data_addr = '0;
  logic [31:0]   i_data_wdata = '0;
  logic [2:0]    i_data_ctrl = '0;
  logic [127:0]  o_insn_data;
  logic [127:0]  o_data_data;
  logic          o_busy;
  logic          o_insn_done;
  logic          o_data_done;
  logic [1:0]    o_err;
  logic          o_overrun;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [31:0]   o_mem_addr;
  logic [127:0]  o_mem_wdata;
  logic [15:0]   o_mem_wmask;
  logic          i_mem_ack = 1'b0;
  logic          i_mem_rvalid = 1'b0;
  logic [127:0]  i_mem_rdata = '0;

  always #5 CLK = ~CLK;

  core_mem_responder #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .i_insn_req(i_insn_req), .i_insn_addr(i_insn_addr),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .i_data_ctrl(i_data_ctrl),
    .o_insn_data(o_insn_data), .o_data_data(o_data_data), .o_busy(o_busy),
    .o_insn_done(o_insn_done), .o_data_done(o_data_done), .o_err(o_err),
    .o_overrun(o_overrun), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_ack(i_mem_ack), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    string        name;
    logic         is_insn;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [2:0]   ctrl;
    logic [127:0] rdata;
    logic         exp_req;
    logic [31:0]  exp_addr;
    logic [15:0]  exp_mask;
    logic [127:0] exp_wdata;
    logic [1:0]   exp_err;
  } vec_t;

  vec_t         vecs[10];
  int           n_checks = 0;
  int           n_fails = 0;
  int           insn_done_cnt = 0;
  int           data_done_cnt = 0;
  int           overrun_cnt = 0;
  logic [127:0] exp_insn_line = '0;
  logic [127:0] exp_data_line = '0;

  always @(negedge CLK) begin
    if (o_insn_done === 1'b1) insn_done_cnt++;
    if (o_data_done === 1'b1) data_done_cnt++;
    if (o_overrun === 1'b1)   overrun_cnt++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_insn) begin
      i_insn_req  = 1'b1;
      i_insn_addr = v.addr;
    end else begin
      i_data_req   = 1'b1;
      i_data_we    = v.we;
      i_data_addr  = v.addr;
      i_data_wdata = v.wdata;
      i_data_ctrl  = v.ctrl;
    end
    tick();
    i_insn_req = 1'b0;
    i_data_req = 1'b0;
    check({v.name, " mem_req"}, 128'(o_mem_req), 128'(v.exp_req));
    if (v.exp_req) begin
      check({v.name, " mem_addr"}, 128'(o_mem_addr), 128'(v.exp_addr));
      check({v.name, " mem_we"}, 128'(o_mem_we), 128'(v.we));
      if (v.we) begin
        check({v.name, " wmask"}, 128'(o_mem_wmask), 128'(v.exp_mask));
        check({v.name, " wdata"}, o_mem_wdata, v.exp_wdata);
      end
      tick();
      check({v.name, " req held"}, 128'(o_mem_req), 128'(1));
      i_mem_ack = 1'b1;
      tick();
      i_mem_ack = 1'b0;
      if (!v.we) begin
        check({v.name, " req dropped"}, 128'(o_mem_req), 128'(0));
        tick();
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = v.rdata;
        tick();
        i_mem_rvalid = 1'b0;
        if (v.is_insn) exp_insn_line = v.rdata;
        else           exp_data_line = v.rdata;
      end
    end
    check({v.name, " insn_done"}, 128'(o_insn_done), 128'(v.is_insn));
    check({v.name, " data_done"}, 128'(o_data_done), 128'(!v.is_insn));
    check({v.name, " err"}, 128'(o_err), 128'(v.exp_err));
    check({v.name, " insn_data"}, o_insn_data, exp_insn_line);
    check({v.name, " data_data"}, o_data_data, exp_data_line);
    tick();
    check({v.name, " done cleared"}, 128'({o_insn_done, o_data_done}), 128'(0));
    check({v.name, " idle"}, 128'(o_busy), 128'(0));
    $display("txn %-14s addr=%h err=%0d", v.name, v.addr, o_err);
  endtask

  initial begin
    int ic, dc, oc;

    vecs[0] = '{"fetch", 1'b1, 1'b0, 32'h8000_0014, 32'h0, 3'd2,
                128'h0123_4567_89AB_CDEF_0011_2233_4455_CAFE,
                1'b1, 32'h8000_0010, 16'h0, 128'h0, 2'd0};
    vecs[1] = '{"load_w", 1'b0, 1'b0, 32'h0000_0100, 32'h0, 3'd2,
                128'hA5A5_0000_1111_2222_3333_4444_5555_6666,
                1'b1, 32'h0000_0100, 16'h0, 128'h0, 2'd0};
    vecs[2] = '{"store_b", 1'b0, 1'b1, 32'h0000_1007, 32'h1234_56AB, 3'd0, 128'h0,
                1'b1, 32'h0000_1000, 16'h0080,
                128'h0000_0000_0000_0000_ABAB_ABAB_0000_0000, 2'd0};
    vecs[3] = '{"store_h", 1'b0, 1'b1, 32'h0000_2006, 32'h0000_1234, 3'd1, 128'h0,
                1'b1, 32'h0000_2000, 16'h00C0,
                128'h0000_0000_0000_0000_1234_1234_0000_0000, 2'd0};
    vecs[4] = '{"store_w", 1'b0, 1'b1, 32'h0000_300C, 32'hDEAD_BEEF, 3'd2, 128'h0,
                1'b1, 32'h0000_3000, 16'hF000,
                128'hDEAD_BEEF_0000_0000_0000_0000_0000_0000, 2'd0};
    vecs[5] = '{"store_w_mis", 1'b0, 1'b1, 32'h0000_3002, 32'h1111_2222, 3'd2, 128'h0,
                1'b0, 32'h0, 16'h0, 128'h0, 2'd1};
    vecs[6] = '{"load_h_mis", 1'b0, 1'b0, 32'h0000_0005, 32'h0, 3'd1, 128'h0,
                1'b0, 32'h0, 16'h0, 128'h0, 2'd1};
    vecs[7] = '{"load_size3", 1'b0, 1'b0, 32'h0000_0000, 32'h0, 3'd3, 128'h0,
                1'b0, 32'h0, 16'h0, 128'h0, 2'd1};
    vecs[8] = '{"store_b_c4", 1'b0, 1'b1, 32'h0000_4001, 32'h0000_005A, 3'd4, 128'h0,
                1'b1, 32'h0000_4000, 16'h0002,
                128'h0000_0000_0000_0000_0000_0000_5A5A_5A5A, 2'd0};
    vecs[9] = '{"load_h", 1'b0, 1'b0, 32'h0000_004A, 32'h0, 3'd1,
                128'hFEDC_BA98_7654_3210_0F0F_F0F0_1357_9BDF,
                1'b1, 32'h0000_0040, 16'h0, 128'h0, 2'd0};

    // reset state
    repeat (3) tick();
    check("rst busy", 128'(o_busy), 128'(0));
    check("rst mem_req", 128'(o_mem_req), 128'(0));
    check("rst strobes", 128'({o_insn_done, o_data_done, o_overrun, o_mem_we}), 128'(0));
    check("rst err", 128'(o_err), 128'(0));
    check("rst mem_addr", 128'(o_mem_addr), 128'(0));
    check("rst wmask", 128'(o_mem_wmask), 128'(0));
    check("rst wdata", o_mem_wdata, 128'h0);
    check("rst insn_data", o_insn_data, 128'h0);
    check("rst data_data", o_data_data, 128'h0);
    RST_X = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // simultaneous fetch and load: load first, fetch on the next ISSUE
    ic = insn_done_cnt; dc = data_done_cnt; oc = overrun_cnt;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h0000_0100; i_data_ctrl = 3'd2;
    i_insn_req = 1'b1; i_insn_addr = 32'h2000_0044;
    tick();
    i_data_req = 1'b0; i_insn_req = 1'b0;
    check("arb first addr", 128'(o_mem_addr), 128'(32'h0000_0100));
    check("arb first req", 128'(o_mem_req), 128'(1));
    i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 128'h1111_0000_2222_0000_3333_0000_4444_0000;
    tick(); i_mem_rvalid = 1'b0;
    exp_data_line = 128'h1111_0000_2222_0000_3333_0000_4444_0000;
    check("arb data_done", 128'({o_data_done, o_insn_done}), 128'(2'b10));
    check("arb data_data", o_data_data, exp_data_line);
    tick();
    check("arb gap req", 128'(o_mem_req), 128'(0));
    tick();
    check("arb fetch req", 128'(o_mem_req), 128'(1));
    check("arb fetch addr", 128'(o_mem_addr), 128'(32'h2000_0040));
    // rvalid coinciding with ack must be ignored
    i_mem_ack = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 128'hBAD0_BAD0;
    tick(); i_mem_ack = 1'b0;
    i_mem_rdata = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    tick(); i_mem_rvalid = 1'b0;
    exp_insn_line = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    check("arb insn_done", 128'(o_insn_done), 128'(1));
    check("arb insn_data", o_insn_data, exp_insn_line);
    tick();
    check("arb done counts", 128'({insn_done_cnt - ic, data_done_cnt - dc}), 128'({32'd1, 32'd1}));
    check("arb no overrun", 128'(overrun_cnt - oc), 128'(0));
    $display("txn arbitration  load 0x100 then fetch 0x20000044");

    // timeout with TIMEOUT=8
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h0000_0200; i_data_ctrl = 3'd2;
    tick(); i_data_req = 1'b0;
    i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
    repeat (7) tick();
    check("tmo early done", 128'(o_data_done), 128'(0));
    check("tmo early busy", 128'(o_busy), 128'(1));
    tick();
    exp_data_line = '0;
    check("tmo done", 128'(o_data_done), 128'(1));
    check("tmo err", 128'(o_err), 128'(2));
    check("tmo data", o_data_data, exp_data_line);
    tick();
    check("tmo cleared", 128'({o_data_done, o_busy}), 128'(0));
    $display("txn timeout      load 0x200");

    // overrun while a load is in WAIT_R
    dc = data_done_cnt;
    i_data_req = 1'b1; i_data_addr = 32'h0000_0300;
    tick(); i_data_req = 1'b0;
    i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
    i_data_req = 1'b1; i_data_addr = 32'h0000_0400;
    tick(); i_data_req = 1'b0;
    check("ovr pulse", 128'(o_overrun), 128'(1));
    tick();
    check("ovr one cycle", 128'(o_overrun), 128'(0));
    i_mem_rvalid = 1'b1; i_mem_rdata = 128'hC0DE_C0DE_0000_0000_0000_0000_C0DE_C0DE;
    tick(); i_mem_rvalid = 1'b0;
    exp_data_line = 128'hC0DE_C0DE_0000_0000_0000_0000_C0DE_C0DE;
    check("ovr done", 128'(o_data_done), 128'(1));
    check("ovr data", o_data_data, exp_data_line);
    check("ovr addr kept", 128'(o_mem_addr), 128'(32'h0000_0300));
    repeat (2) tick();
    check("ovr no 2nd op", 128'({o_mem_req, o_busy}), 128'(0));
    check("ovr done count", 128'(data_done_cnt - dc), 128'(1));
    $display("txn overrun      load 0x300, dropped 0x400");

    // reset during ISSUE, late ack/rvalid ignored
    ic = insn_done_cnt; dc = data_done_cnt;
    i_insn_req = 1'b1; i_insn_addr = 32'h0000_1000;
    tick(); i_insn_req = 1'b0;
    check("rstmid req", 128'(o_mem_req), 128'(1));
    RST_X = 1'b0;
    tick();
    RST_X = 1'b1;
    exp_insn_line = '0; exp_data_line = '0;
    check("rstmid req drop", 128'({o_mem_req, o_busy}), 128'(0));
    check("rstmid insn_data", o_insn_data, exp_insn_line);
    check("rstmid data_data", o_data_data, exp_data_line);
    i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
    i_mem_rvalid = 1'b1; i_mem_rdata = 128'hDEAD; tick(); i_mem_rvalid = 1'b0;
    tick();
    check("rstmid no done", 128'({insn_done_cnt - ic, data_done_cnt - dc}), 128'(0));
    check("rstmid still idle", 128'({o_mem_req, o_busy}), 128'(0));
    check("rstmid insn stays 0", o_insn_data, exp_insn_line);
    $display("txn reset-mid    fetch 0x1000 aborted");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
